// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory (2**AW x DW) between the CPU
//   and a host loader port. Each access takes three cycles:
//   IDLE (arbitrate and latch), GRANT (memory strobe), DONE (read data back).
//
//   Arbitration in IDLE, first match wins:
//     single requester wins; halt -> host; host starved (wait_cnt >= MAX_WAIT)
//     -> host; otherwise the CPU.
//   Build option ARB_ROUND_ROBIN_EN: on contention the requester not granted
//   last wins (the CPU wins the first tie); halt still forces the host.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   halt                          CPU halted, host gets priority
//   cpu_req/we/addr/wdata         CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid           CPU grant pulse, CPU read data valid
//   host_req/we/addr/wdata        host request, same rules as the CPU
//   host_gnt, host_rvalid         host grant pulse, host read data valid
//   rdata                         read data (mem_rdata), qualified by *_rvalid
//   mem_en/we/addr/wdata          memory strobe, write enable, address, data
//   mem_rdata                     memory read data, valid the cycle after mem_en
//   busy                          access in progress
module mem_port_arbiter #(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    state_t  state, state_nxt;
    logic    owner_host;   // 0 = CPU owns the access, 1 = host
    logic    we_lat;
    logic    host_wins;
    logic    any_req;

    assign any_req = cpu_req | host_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Last requester granted; starts as host so the CPU wins the first tie.
    logic last_host;

    always_comb begin
        host_wins = 1'b0;
        if (host_req && !cpu_req)
            host_wins = 1'b1;
        else if (host_req && cpu_req)
            host_wins = halt ? 1'b1 : !last_host;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_host <= 1'b1;
        else if (state == IDLE && any_req)
            last_host <= host_wins;
    end
`else
    logic [3:0] wait_cnt;   // consecutive host losses to the CPU

    always_comb begin
        host_wins = 1'b0;
        if (host_req && !cpu_req)
            host_wins = 1'b1;
        else if (host_req && cpu_req)
            host_wins = halt || (wait_cnt >= 4'(MAX_WAIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (state == IDLE && any_req) begin
            if (host_wins)
                wait_cnt <= 4'd0;
            else if (host_req && wait_cnt != 4'd15)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and outputs
    always_comb begin
        state_nxt   = state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        cpu_gnt     = 1'b0;
        host_gnt    = 1'b0;
        cpu_rvalid  = 1'b0;
        host_rvalid = 1'b0;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = GRANT;
            end
            GRANT: begin
                mem_en    = 1'b1;
                mem_we    = we_lat;
                cpu_gnt   = !owner_host;
                host_gnt  = owner_host;
                state_nxt = DONE;
            end
            DONE: begin
                cpu_rvalid  = !we_lat && !owner_host;
                host_rvalid = !we_lat && owner_host;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Winner's request is captured once in IDLE so that halt or request
    // changes during GRANT/DONE cannot disturb the access in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_host <= 1'b0;
            we_lat     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (state == IDLE && any_req) begin
            owner_host <= host_wins;
            we_lat     <= host_wins ? host_we    : cpu_we;
            mem_addr   <= host_wins ? host_addr  : cpu_addr;
            mem_wdata  <= host_wins ? host_wdata : cpu_wdata;
        end
    end

    assign rdata = mem_rdata;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          halt = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory model
    logic [DW-1:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          c_req, c_we;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wd;
        logic          h_req, h_we;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_wd;
        logic          hlt;
        logic          exp_host;
        logic [DW-1:0] exp_rd;
    } vec_t;

    // One full access starting at a negedge with the DUT in IDLE.
    task automatic access(input vec_t v, input int idx);
        logic          w_we;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_wd;
        w_we   = v.exp_host ? v.h_we   : v.c_we;
        w_addr = v.exp_host ? v.h_addr : v.c_addr;
        w_wd   = v.exp_host ? v.h_wd   : v.c_wd;
        cpu_req  = v.c_req; cpu_we  = v.c_we; cpu_addr  = v.c_addr; cpu_wdata  = v.c_wd;
        host_req = v.h_req; host_we = v.h_we; host_addr = v.h_addr; host_wdata = v.h_wd;
        halt     = v.hlt;
        @(negedge clk);
        chk($sformatf("v%0d gnt", idx), {cpu_gnt, host_gnt}, v.exp_host ? 2'b01 : 2'b10);
        chk($sformatf("v%0d mem_en", idx), mem_en, 1'b1);
        chk($sformatf("v%0d mem_we", idx), mem_we, w_we);
        chk($sformatf("v%0d mem_addr", idx), mem_addr, w_addr);
        if (w_we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, w_wd);
        cpu_req = 1'b0; host_req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d rvalid", idx), {cpu_rvalid, host_rvalid},
            w_we ? 2'b00 : (v.exp_host ? 2'b01 : 2'b10));
        if (!w_we) chk($sformatf("v%0d rdata", idx), rdata, v.exp_rd);
        chk($sformatf("v%0d done", idx), {busy, mem_en, cpu_gnt, host_gnt}, 4'b1000);
        @(negedge clk);
        chk($sformatf("v%0d idle", idx), busy, 1'b0);
        halt = 1'b0;
    endtask

    // Both requesters read continuously; bit k of order = 1 if grant k went to host.
    task automatic contend(input int n, output logic [15:0] order);
        int got = 0;
        int cyc = 0;
        order = '0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'd3;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cpu_gnt || host_gnt) begin
                order[got] = host_gnt;
                got++;
            end
        end
        cpu_req = 1'b0; host_req = 1'b0;
        chk("contend grants seen", got, n);
        repeat (2) @(negedge clk);
    endtask

    vec_t        vecs[7];
    logic [15:0] order;
    logic [15:0] exp_order;
    int          seen;

    initial begin
        //          c_req c_we c_addr c_wd   h_req h_we h_addr h_wd   halt host rd
        vecs[0] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1, 5'd3,  8'h5A, 1'b0, 1'b1, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd3,  8'h00, 1'b0, 1'b1, 8'h5A};
        vecs[2] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1, 5'h1F, 8'hFF, 1'b0, 1'b1, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 5'h1F, 8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 8'hFF};
        vecs[4] = '{1'b1, 1'b1, 5'd7,  8'h3C, 1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 5'd7,  8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 8'h3C};
        vecs[6] = '{1'b1, 1'b1, 5'd8,  8'h11, 1'b1, 1'b0, 5'd7,  8'h00, 1'b1, 1'b1, 8'h3C};

        // Reset state
        #2;
        chk("reset outputs", {busy, mem_en, mem_we, cpu_gnt, host_gnt, cpu_rvalid, host_rvalid}, 7'd0);
        chk("reset mem_addr/wdata", {mem_addr, mem_wdata}, 13'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) access(vecs[i], i);

        // Continuous contention, halt low
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = 16'b10_1010_1010;   // C,H,C,H,...
`else
        exp_order = 16'b10_0001_0000;   // C,C,C,C,H,C,C,C,C,H
`endif
        contend(10, order);
        chk("contention order", order[9:0], exp_order[9:0]);

        // Halt high: host takes every grant; CPU only after halt falls
        halt = 1'b1;
        contend(4, order);
        chk("halt order", order[3:0], 4'b1111);
        halt = 1'b0;
        contend(1, order);
        chk("after halt", order[0], 1'b0);

        // Reset during GRANT of a CPU write to addr 7
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd7; cpu_wdata = 8'h99;
        @(negedge clk);
        chk("pre-reset grant", {mem_en, mem_we, cpu_gnt}, 3'b111);
        rst = 1'b1;
        #1;
        chk("reset mid-access", {busy, mem_en, mem_we, cpu_gnt, host_gnt}, 5'd0);
        chk("reset mid mem_addr", {mem_addr, mem_wdata}, 13'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_gnt || cpu_rvalid || busy) seen++;
        end
        chk("no gnt after reset", seen, 0);
        // Abandoned write must not have reached memory
        access('{1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b1, 8'h3C}, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Overall time bound
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single-port 32x8 program/data memory between two requesters: the CPU (control unit + datapath fetch/load/store) and a host loader port that writes programs and reads results.
- Fixed CPU priority, with a starvation limit for the host and full host priority while the CPU is halted.
- Sits between the top level's controller/datapath memory interface and the memory array.

Parameters:
AW, 5, address width (32 words)
DW, 8, data width
MAX_WAIT, 4, consecutive host losses before the host is forced to win (1..15)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Halt  in  1  CPU halted; host gets priority while high
cpu_req  in  1  CPU access request; held with addr/we/wdata until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  one-cycle grant pulse
cpu_rvalid  out  1  CPU read data valid
host_req, host_we, host_addr, host_wdata  in  1/1/AW/DW  host request, same rules as CPU
host_gnt  out  1  one-cycle grant pulse
host_rvalid  out  1  host read data valid
rdata  out  DW  read data, shared by both requesters, qualified by *_rvalid
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  synchronous memory read data, valid the cycle after mem_en
busy  out  1  access in progress (state != IDLE)

Behaviour:
- FSM states: IDLE, GRANT, DONE.
- IDLE: if any req is high, pick a winner, latch its we/addr/wdata into mem_* registers and record the owner, then go to GRANT. If no req, stay in IDLE.
- GRANT (1 cycle): mem_en=1. mem_we/mem_addr/mem_wdata come from the latched registers. The owner's gnt=1. Next state is DONE.
- DONE (1 cycle): mem_en=0. If the owner's access was a read, the owner's rvalid=1 and rdata=mem_rdata (combinational pass-through). Next state is IDLE.
- One access per 3 cycles; requests are sampled only in IDLE.
- A requester must deassert req, or present a new request, by DONE. A req still high in IDLE is a new access.
- Priority in IDLE, first match wins:
  1. Only one req high: that requester wins.
  2. Halt=1: host wins.
  3. wait_cnt >= MAX_WAIT: host wins.
  4. Otherwise the CPU wins.
- wait_cnt (4 bits):
  - Increments, saturating at 15, when host_req=1 and the CPU wins.
  - Clears to 0 when the host is granted.
  - Holds otherwise.
- Halt changing during GRANT or DONE does not affect the access in progress.
- Reset (asynchronous, mid-access included):
  - State goes to IDLE and the owner register to CPU; wait_cnt=0.
  - mem_en, mem_we, cpu_gnt, host_gnt, cpu_rvalid, host_rvalid and busy drop to 0 immediately.
  - mem_addr=0, mem_wdata=0.
  - An in-flight access is abandoned: no gnt/rvalid follows after release.
- rdata is driven from mem_rdata at all times; it is meaningful only when an rvalid is high.
- Writes produce no rvalid.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: fixed priority and wait_cnt are removed. When both requesters contend, the requester not granted last wins; the last-granted register resets to host, so the CPU wins the first tie. Halt still forces the host to win.
- Undefined: fixed-priority behaviour with the MAX_WAIT starvation limit, as above.

Test Plan:
- Host write 0x5A to addr 3 with no CPU req -> host_gnt in cycle 2, mem_we=1, mem_addr=3, mem_wdata=0x5A. Then a host read of addr 3 -> host_rvalid in DONE with rdata=0x5A, cpu_rvalid=0.
- CPU and host request continuously, Halt=0, MAX_WAIT=4 -> grant order C,C,C,C,H,C,C,C,C,H. wait_cnt returns to 0 after each H.
- Same contention with Halt=1 -> every grant goes to the host while Halt is high; the CPU is granted only after Halt falls.
- Reset asserted during GRANT of a CPU write to addr 7 -> mem_en/mem_we drop in the same cycle, no cpu_gnt after release, busy=0, next grant decided from IDLE.
- CPU reads addr 0x1F after the host wrote 0xFF there -> cpu_rvalid one cycle after cpu_gnt, rdata=0xFF, host_gnt and host_rvalid stay 0.
- With ARB_ROUND_ROBIN_EN, continuous contention -> grants alternate C,H,C,H.
